// File: rtl/b13_serial_pkg.sv
// b13_serial_pkg
// Shared definitions for the b13 serial transmitter / receiver pair.
//   rx_state_t          receiver state encodings
//   DEFAULT_BIT_PERIOD  clocks between symbol strobes (transmitter delay 104 + 2)
//   FRAME_BITS          data bits per frame, sent MSB first
//   START_SYMBOL/STOP_SYMBOL  line levels the transmitter uses for framing
package b13_serial_pkg;

    typedef enum logic [1:0] {
        RX_IDLE = 2'b00,
        RX_DATA = 2'b01,
        RX_STOP = 2'b10
    } rx_state_t;

    localparam int DEFAULT_BIT_PERIOD = 106;
    localparam int FRAME_BITS         = 8;

    localparam logic START_SYMBOL = 1'b0;
    localparam logic STOP_SYMBOL  = 1'b1;

endpackage

// File: rtl/b13_bit_timer.sv
// b13_bit_timer
// Counts clocks between symbol strobes of a frame in progress.
//   clock    sole clock
//   reset    synchronous, active-high
//   restart  holds the count at zero (asserted while the receiver is idle)
//   strobe   high on the cycle the count reaches BIT_PERIOD-1
module b13_bit_timer
    import b13_serial_pkg::*;
#(
    parameter int BIT_PERIOD = DEFAULT_BIT_PERIOD
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    output logic strobe
);

    localparam logic [9:0] LAST_COUNT = 10'(BIT_PERIOD - 1);

    logic [9:0] tmr;

    assign strobe = (tmr == LAST_COUNT) && !restart;

    // The count folds back to zero on each strobe, so it never wraps
    // within its 10 bits for any period up to 1023.
    always_ff @(posedge clock) begin
        if (reset || restart || strobe) begin
            tmr <= '0;
        end else begin
            tmr <= tmr + 10'd1;
        end
    end

endmodule

// File: rtl/b13_serial_rx.sv
// b13_serial_rx
// Recovers strobed frames (start, 8 data bits MSB first, stop) from the
// b13 transmitter line and holds each byte for a valid/ack consumer.
//   clock        sole clock
//   reset        synchronous, active-high
//   rx_in        serial line, idles high, only strobe cycles are sampled
//   rd_ack       consumer takes rx_data (ignored while rx_valid is low)
//   rx_data      held byte, bit 7 is the first data bit received
//   rx_valid     holding register full
//   frame_error  sticky, a stop sample was 0
//   overrun      sticky, a frame completed while the holding register was full
//   busy         a frame is in progress
module b13_serial_rx
    import b13_serial_pkg::*;
#(
    parameter int BIT_PERIOD = DEFAULT_BIT_PERIOD
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_in,
    input  logic       rd_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_error,
    output logic       overrun,
    output logic       busy
);

    rx_state_t             state;
    rx_state_t             state_next;
    logic [3:0]            bit_cnt;
    logic [FRAME_BITS-1:0] shift;
    logic                  strobe;
    logic                  start_seen;
    logic                  data_strobe;
    logic                  stop_strobe;

    b13_bit_timer #(
        .BIT_PERIOD (BIT_PERIOD)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .restart (state == RX_IDLE),
        .strobe  (strobe)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= RX_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: the last data sample moves to the stop symbol, and the
    // stop sample returns to idle so start detection is live next cycle.
    always_comb begin
        state_next = state;
        unique case (state)
            RX_IDLE: if (rx_in == START_SYMBOL) state_next = RX_DATA;
            RX_DATA: if (strobe && (bit_cnt == 4'(FRAME_BITS - 1))) state_next = RX_STOP;
            RX_STOP: if (strobe) state_next = RX_IDLE;
            default: state_next = RX_IDLE;
        endcase
    end

    // Decoded per-state actions for the datapath.
    always_comb begin
        busy        = 1'b0;
        start_seen  = 1'b0;
        data_strobe = 1'b0;
        stop_strobe = 1'b0;
        unique case (state)
            RX_IDLE: start_seen = (rx_in == START_SYMBOL);
            RX_DATA: begin
                busy        = 1'b1;
                data_strobe = strobe;
            end
            RX_STOP: begin
                busy        = 1'b1;
                stop_strobe = strobe;
            end
            default: ;
        endcase
    end

    // Shift register, holding register and sticky flags. An ack arriving
    // on the delivery cycle frees the slot for the new byte, so valid stays
    // high and no overrun is recorded.
    always_ff @(posedge clock) begin
        if (reset) begin
            bit_cnt     <= '0;
            shift       <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (start_seen) begin
                bit_cnt <= '0;
            end else if (data_strobe) begin
                shift   <= {shift[FRAME_BITS-2:0], rx_in};
                bit_cnt <= bit_cnt + 4'd1;
            end

            if (stop_strobe) begin
                if (rx_in != STOP_SYMBOL) begin
                    frame_error <= 1'b1;
                end
                if (!rx_valid || rd_ack) begin
                    rx_data  <= shift;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rd_ack && rx_valid) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_b13_serial_rx.sv
// tb_b13_serial_rx
// Directed bench for b13_serial_rx: drives strobed frames the way the b13
// transmitter does and checks the held byte, handshake and sticky flags.
module tb_b13_serial_rx;
    import b13_serial_pkg::*;

    localparam int P = DEFAULT_BIT_PERIOD;

    logic       clock;
    logic       reset;
    logic       rx_in;
    logic       rd_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_error;
    logic       overrun;
    logic       busy;

    int checks = 0;
    int errors = 0;

    b13_serial_rx #(
        .BIT_PERIOD (P)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .rx_in       (rx_in),
        .rd_ack      (rd_ack),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .frame_error (frame_error),
        .overrun     (overrun),
        .busy        (busy)
    );

    // Free-running clock, period 10.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // One comparison: count it, and report tag/observed/expected on a miss.
    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drives one frame starting at the next rising edge. Between strobes the
    // line toggles so any off-strobe sampling corrupts the byte. Returns on
    // the falling edge after the stop sample, where delivery is visible.
    task automatic applyStimulus(input logic [7:0] value, input logic stop, input logic ackStop);
        int k;
        @(negedge clock);
        checkOutput("busy_before_start", {7'd0, busy}, 8'd0);
        rx_in  = 1'b0;
        rd_ack = 1'b0;
        for (int c = 1; c <= 9 * P; c++) begin
            @(negedge clock);
            rd_ack = 1'b0;
            if (c % P == 0) begin
                k = c / P - 1;
                if (k < 8) begin
                    rx_in = value[7 - k];
                end else begin
                    rx_in  = stop;
                    rd_ack = ackStop;
                    checkOutput("busy_at_stop", {7'd0, busy}, 8'd1);
                end
            end else begin
                rx_in = c[0];
            end
        end
        @(negedge clock);
        rx_in  = 1'b1;
        rd_ack = 1'b0;
    endtask

    // One-cycle acknowledge pulse, returns on the following falling edge.
    task automatic pulseAck();
        @(negedge clock);
        rd_ack = 1'b1;
        @(negedge clock);
        rd_ack = 1'b0;
    endtask

    task automatic doReset(input int cycles);
        @(negedge clock);
        reset = 1'b1;
        rx_in = 1'b1;
        rd_ack = 1'b0;
        repeat (cycles) @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        rx_in  = 1'b1;
        rd_ack = 1'b0;

        // Reset state
        doReset(2);
        checkOutput("reset_rx_data", rx_data, 8'h00);
        checkOutput("reset_rx_valid", {7'd0, rx_valid}, 8'd0);
        checkOutput("reset_frame_error", {7'd0, frame_error}, 8'd0);
        checkOutput("reset_overrun", {7'd0, overrun}, 8'd0);
        checkOutput("reset_busy", {7'd0, busy}, 8'd0);

        // Single byte 0xA5, good stop
        applyStimulus(8'hA5, 1'b1, 1'b0);
        checkOutput("a5_rx_valid", {7'd0, rx_valid}, 8'd1);
        checkOutput("a5_rx_data", rx_data, 8'hA5);
        checkOutput("a5_frame_error", {7'd0, frame_error}, 8'd0);
        checkOutput("a5_overrun", {7'd0, overrun}, 8'd0);
        checkOutput("a5_busy_after", {7'd0, busy}, 8'd0);

        // Ack clears valid; a second ack with nothing held is ignored
        pulseAck();
        checkOutput("ack_rx_valid", {7'd0, rx_valid}, 8'd0);
        checkOutput("ack_rx_data_kept", rx_data, 8'hA5);
        pulseAck();
        checkOutput("idle_ack_rx_valid", {7'd0, rx_valid}, 8'd0);

        // Framing error on 0x3C, byte still delivered
        applyStimulus(8'h3C, 1'b0, 1'b0);
        checkOutput("3c_rx_data", rx_data, 8'h3C);
        checkOutput("3c_rx_valid", {7'd0, rx_valid}, 8'd1);
        checkOutput("3c_frame_error", {7'd0, frame_error}, 8'd1);
        pulseAck();

        // Overrun: 0x11 left unacked, then 0x22 is discarded
        applyStimulus(8'h11, 1'b1, 1'b0);
        checkOutput("11_rx_data", rx_data, 8'h11);
        checkOutput("fe_sticky", {7'd0, frame_error}, 8'd1);
        checkOutput("11_overrun", {7'd0, overrun}, 8'd0);
        applyStimulus(8'h22, 1'b1, 1'b0);
        checkOutput("ovr_rx_data", rx_data, 8'h11);
        checkOutput("ovr_overrun", {7'd0, overrun}, 8'd1);
        checkOutput("ovr_rx_valid", {7'd0, rx_valid}, 8'd1);

        // Reset clears sticky flags
        doReset(2);
        checkOutput("rst2_frame_error", {7'd0, frame_error}, 8'd0);
        checkOutput("rst2_overrun", {7'd0, overrun}, 8'd0);

        // Ack on the delivery cycle: new byte replaces old, no overrun
        applyStimulus(8'h11, 1'b1, 1'b0);
        applyStimulus(8'h22, 1'b1, 1'b1);
        checkOutput("ackdel_rx_data", rx_data, 8'h22);
        checkOutput("ackdel_rx_valid", {7'd0, rx_valid}, 8'd1);
        checkOutput("ackdel_overrun", {7'd0, overrun}, 8'd0);

        // Reset during bit 4 of 0xFF
        @(negedge clock);
        rx_in = 1'b0;
        for (int c = 1; c <= 4 * P + 50; c++) begin
            @(negedge clock);
            rx_in = (c % P == 0) ? 1'b1 : c[0];
        end
        checkOutput("mid_busy_before", {7'd0, busy}, 8'd1);
        reset = 1'b1;
        rx_in = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkOutput("mid_busy", {7'd0, busy}, 8'd0);
        checkOutput("mid_rx_valid", {7'd0, rx_valid}, 8'd0);
        checkOutput("mid_frame_error", {7'd0, frame_error}, 8'd0);
        checkOutput("mid_overrun", {7'd0, overrun}, 8'd0);
        applyStimulus(8'h81, 1'b1, 1'b0);
        checkOutput("81_rx_data", rx_data, 8'h81);
        checkOutput("81_rx_valid", {7'd0, rx_valid}, 8'd1);
        checkOutput("81_frame_error", {7'd0, frame_error}, 8'd0);
        pulseAck();

        // Transmitter-style stream: three 0xC3 frames, each consumed
        for (int f = 0; f < 3; f++) begin
            repeat (3) @(negedge clock);
            applyStimulus(8'hC3, 1'b1, 1'b0);
            checkOutput("c3_rx_data", rx_data, 8'hC3);
            checkOutput("c3_rx_valid", {7'd0, rx_valid}, 8'd1);
            pulseAck();
        end
        checkOutput("c3_overrun", {7'd0, overrun}, 8'd0);
        checkOutput("c3_frame_error", {7'd0, frame_error}, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/b13_serial_rx.md
# b13_serial_rx

Receive stage placed directly downstream of the b13 serial transmitter. It watches the transmitter's `data_out` line and recovers each 10-symbol frame: one start symbol, eight data bits MSB first, one stop symbol. Each symbol appears on the line for exactly one clock, and symbols are spaced `BIT_PERIOD` clocks apart. The recovered byte goes into a one-entry holding register with a valid/ack handshake to the consumer, and the block flags framing and overrun errors.

## Interface
- `BIT_PERIOD`, default 106: clocks between consecutive symbol strobes. This equals the transmitter delay of 104 plus 2. Legal range is 2..1023.
- `clock`  input  1  sole clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `rx_in`  input  1  serial line. It idles high, and a symbol is valid only on its strobe cycle.
- `rd_ack`  input  1  consumer accepts `rx_data`. Only meaningful while `rx_valid`=1.
- `rx_data`  output  8  held byte, bit 7 = first data bit received. Reset value 0.
- `rx_valid`  output  1  holding register full. Reset value 0.
- `frame_error`  output  1  sticky; set when a stop sample is 0. Reset value 0.
- `overrun`  output  1  sticky; set when a frame completes while the holding register is still full. Reset value 0.
- `busy`  output  1  high while a frame is in progress (state ≠ RX_IDLE). Reset value 0.

## Operation
- The state machine has three states: RX_IDLE, RX_DATA and RX_STOP. Reset forces RX_IDLE, `bit_cnt`=0, `tmr`=0, `shift`=0, and all outputs to 0.
- **RX_IDLE:** when `rx_in`=0, this cycle is the start strobe.
  - Load `tmr`=0 and `bit_cnt`=0.
  - Go to RX_DATA.
  - `rx_in`=1 keeps the block in RX_IDLE.
- **RX_DATA:** `tmr` increments every cycle.
  - When `tmr`=BIT_PERIOD-1, the cycle is a sample strobe: `shift` ← {`shift`[6:0], `rx_in`}, `tmr` ← 0, `bit_cnt` ← `bit_cnt`+1.
  - After the 8th sample (`bit_cnt` reaches 8), go to RX_STOP.
- **RX_STOP:** on the strobe at `tmr`=BIT_PERIOD-1, sample `rx_in`.
  - If the sample is 0, set `frame_error`. The byte is still delivered.
  - Delivery: if `rx_valid`=0, or `rd_ack`=1 in the same cycle, load `rx_data` ← `shift` and set `rx_valid`=1. Otherwise set `overrun` and discard `shift`; `rx_data` is unchanged.
  - Return to RX_IDLE. Start detection is live from the next cycle.
- **Handshake:** `rd_ack`=1 with `rx_valid`=1 and no simultaneous delivery clears `rx_valid` next cycle. `rd_ack` with `rx_valid`=0 is ignored.
- **Sticky flags:** `frame_error` and `overrun` clear only on `reset`.
- **Counter width:** `tmr` is 10 bits unsigned and never wraps, since it resets at BIT_PERIOD-1. `bit_cnt` is 4 bits.
- **Reset mid-frame:** the partial frame is discarded, `rx_valid` is cleared, and no flag is set.

## Timing
- With the start strobe at cycle t:
  - data bit k (k=0..7, MSB first) is sampled at t+(k+1)·BIT_PERIOD;
  - the stop symbol is sampled at t+9·BIT_PERIOD;
  - `rx_valid` and `rx_data` are visible at t+9·BIT_PERIOD+1.
- With the default period, delivery is 955 clocks after the start strobe.
- `busy` is high from t+1 through t+9·BIT_PERIOD inclusive.
- Line values between strobes are ignored; only the strobe cycle is sampled.
- Delivery and `rd_ack` in the same cycle: the new byte replaces the old one, `rx_valid` stays 1, and there is no overrun.

## Structure
- Shared package `b13_serial_pkg` holds:
  - state encodings RX_IDLE=2'b00, RX_DATA=2'b01, RX_STOP=2'b10;
  - `DEFAULT_BIT_PERIOD`=106;
  - `FRAME_BITS`=8.
- The transmitter's bit encodings move to the same package.
- One sub-module, `b13_bit_timer`, holds the 10-bit `tmr`. It has a `restart` input and a `strobe` output that fires when `tmr`=BIT_PERIOD-1.
- The state machine, shift register and holding register live in `b13_serial_rx`.

## Test plan
- **Single byte:** `reset` for 2 cycles, then drive a strobed frame of 0xA5 with a good stop. Required: `rx_valid`=1 and `rx_data`=8'hA5 at start+955, with `frame_error`=0 and `overrun`=0.
- **Framing error:** frame 0x3C with stop strobe = 0. Required: `rx_data`=8'h3C, `rx_valid`=1, `frame_error`=1, and the flag remains set through the following good frame.
- **Overrun:** send 0x11, do not ack, then send 0x22. Required: `rx_data` stays 8'h11, `overrun`=1 at second-frame delivery.
- **Ack on the delivery cycle:** send 0x11, hold; send 0x22 and pulse `rd_ack` on its stop-sample cycle. Required: `rx_data`=8'h22, `rx_valid`=1, `overrun`=0.
- **Reset mid-frame:** assert `reset` during bit 4 of 0xFF. Required: `busy`=0 and `rx_valid`=0 next cycle. A following 0x81 frame is received correctly.
- **End-to-end:** connect to the b13 transmitter with `dsr`=1 and `data_in`=8'hC3, and run 3 frames. Required: each received byte is 8'hC3, and `busy` is low before every transmitter start strobe.
